// File: rtl/demux3_frame.sv
// demux3_frame: registered 1-to-3 demultiplexer with frame buffering.
// Auto mode gathers three words (U, V, W) into shadow registers and commits
// them to the outputs together; explicit mode routes each word by S.
//
// Handshake: a word on M is taken on a rising edge where Valid=1 and Ready=1.
// Ready depends only on the registered state (low only in ST_COMMIT), never
// on Valid, so a producer may hold Valid high and simply wait for Ready.
module demux3_frame #(
  parameter int WIDTH = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] M,
  input  logic             Valid,
  output logic             Ready,
  input  logic             Mode,
  input  logic [1:0]       S,
  input  logic             Clear,
  output logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] V,
  output logic [WIDTH-1:0] W,
  output logic [2:0]       Strobe,
  output logic [1:0]       Chan,
  output logic             Err
);

  typedef enum logic [1:0] {
    ST_U      = 2'd0,
    ST_V      = 2'd1,
    ST_W      = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_u_q, sh_u_d;
  logic [WIDTH-1:0] sh_v_q, sh_v_d;
  logic [WIDTH-1:0] sh_w_q, sh_w_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [2:0]       strobe_q, strobe_d;
  logic             err_q, err_d;
  logic             accept;

  assign Ready  = (state_q != ST_COMMIT);
  assign accept = Valid & Ready;
  assign Chan   = state_q;
  assign U      = u_q;
  assign V      = v_q;
  assign W      = w_q;
  assign Strobe = strobe_q;
  assign Err    = err_q;

  // Next-state, shadow, output and flag logic; Clear overrides everything
  // except the visible outputs, which hold their last committed values.
  always_comb begin
    state_d  = state_q;
    sh_u_d   = sh_u_q;
    sh_v_d   = sh_v_q;
    sh_w_d   = sh_w_q;
    u_d      = u_q;
    v_d      = v_q;
    w_d      = w_q;
    strobe_d = 3'b000;
    err_d    = err_q;
    if (Clear) begin
      state_d = ST_U;
      sh_u_d  = '0;
      sh_v_d  = '0;
      sh_w_d  = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_U: begin
          if (accept) begin
            if (!Mode) begin
              sh_u_d  = M;
              state_d = ST_V;
            end else begin
              // Explicit routing: the FSM stays in ST_U for every word.
              unique case (S)
                2'd0: begin u_d = M; strobe_d = 3'b001; end
                2'd1: begin v_d = M; strobe_d = 3'b010; end
                2'd2: begin w_d = M; strobe_d = 3'b100; end
                default: err_d = 1'b1;
              endcase
            end
          end
        end
        ST_V: begin
          // Mode is ignored mid-frame; the frame always completes in auto mode.
          if (accept) begin
            sh_v_d  = M;
            state_d = ST_W;
          end
        end
        ST_W: begin
          if (accept) begin
            sh_w_d  = M;
            state_d = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          u_d      = sh_u_q;
          v_d      = sh_v_q;
          w_d      = sh_w_q;
          strobe_d = 3'b111;
          state_d  = ST_U;
        end
        default: state_d = ST_U;
      endcase
    end
  end

  // State and data registers with asynchronous reset to the idle, cleared state.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_U;
      sh_u_q   <= '0;
      sh_v_q   <= '0;
      sh_w_q   <= '0;
      u_q      <= '0;
      v_q      <= '0;
      w_q      <= '0;
      strobe_q <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_u_q   <= sh_u_d;
      sh_v_q   <= sh_v_d;
      sh_w_q   <= sh_w_d;
      u_q      <= u_d;
      v_q      <= v_d;
      w_q      <= w_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_demux3_frame.sv
// Testbench for demux3_frame: directed sequence with a strobe scoreboard.
module tb_demux3_frame;

  localparam int WIDTH = 2;
  localparam int SBW   = 3 + 3 * WIDTH;

  logic             Clock;
  logic             Reset;
  logic [WIDTH-1:0] M;
  logic             Valid;
  logic             Ready;
  logic             Mode;
  logic [1:0]       S;
  logic             Clear;
  logic [WIDTH-1:0] U, V, W;
  logic [2:0]       Strobe;
  logic [1:0]       Chan;
  logic             Err;

  logic [SBW-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  demux3_frame #(.WIDTH(WIDTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .M     (M),
    .Valid (Valid),
    .Ready (Ready),
    .Mode  (Mode),
    .S     (S),
    .Clear (Clear),
    .U     (U),
    .V     (V),
    .W     (W),
    .Strobe(Strobe),
    .Chan  (Chan),
    .Err   (Err)
  );

  // Clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [WIDTH-1:0] eu,
                          input logic [WIDTH-1:0] ev, input logic [WIDTH-1:0] ew);
    exp_q.push_back({st, eu, ev, ew});
  endtask

  // Scoreboard: every nonzero strobe must match the next expected update.
  always @(negedge Clock) begin
    if (Strobe != 3'b000) begin
      if (exp_q.size() == 0) check("unexpected_strobe", {Strobe, U, V, W}, 0);
      else check("strobe_update", {Strobe, U, V, W}, exp_q.pop_front());
    end
  end

  logic [WIDTH-1:0] w0, w1, w2;
  int strobe_pulses;

  initial begin
    Reset = 1'b0; M = '0; Valid = 1'b0; Mode = 1'b0; S = 2'd0; Clear = 1'b0;

    // Reset asserted mid-cycle, before any clock edge.
    #3 Reset = 1'b1;
    #1;
    check("reset_uvw", {U, V, W}, 0);
    check("reset_strobe", Strobe, 0);
    check("reset_err", Err, 0);
    check("reset_chan", Chan, 0);
    check("reset_ready", Ready, 1);
    tick();
    @(negedge Clock) Reset = 1'b0;
    tick();

    // Auto frame 01, 10, 11.
    Mode = 1'b0; Valid = 1'b1; M = 2'b01;
    tick();
    check("auto_chan_v", Chan, 1);
    check("auto_hold_u", U, 0);
    M = 2'b10;
    tick();
    check("auto_chan_w", Chan, 2);
    M = 2'b11;
    push_exp(3'b111, 2'b01, 2'b10, 2'b11);
    tick();
    check("auto_chan_commit", Chan, 3);
    check("auto_ready_low", Ready, 0);
    check("auto_no_partial", {U, V, W}, 0);
    Valid = 1'b0;
    tick();
    check("auto_commit_data", {Strobe, U, V, W}, {3'b111, 2'b01, 2'b10, 2'b11});
    check("auto_back_idle", Chan, 0);
    tick();
    check("auto_strobe_one_cycle", Strobe, 0);

    // Explicit routing.
    Mode = 1'b1; Valid = 1'b1; S = 2'd2; M = 2'b10;
    push_exp(3'b100, 2'b01, 2'b10, 2'b10);
    tick();
    check("expl_w", {Strobe, W}, {3'b100, 2'b10});
    check("expl_chan", Chan, 0);
    S = 2'd0; M = 2'b11;
    push_exp(3'b001, 2'b11, 2'b10, 2'b10);
    tick();
    check("expl_u", {Strobe, U}, {3'b001, 2'b11});
    S = 2'd3; M = 2'b01;
    tick();
    check("expl_illegal", {Strobe, Err, U, V, W}, {3'b000, 1'b1, 2'b11, 2'b10, 2'b10});
    Valid = 1'b0;
    tick();
    tick();
    check("err_sticky", Err, 1);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check("err_cleared", Err, 0);

    // Clear colliding with an accept after two auto words.
    Mode = 1'b0; Valid = 1'b1; M = 2'b00;
    tick();
    M = 2'b01;
    tick();
    check("clr_pre_chan", Chan, 2);
    Clear = 1'b1; M = 2'b11;
    tick();
    Clear = 1'b0;
    check("clr_chan", Chan, 0);
    check("clr_outputs", {Strobe, U, V, W}, {3'b000, 2'b11, 2'b10, 2'b10});
    M = 2'b10;
    tick();
    M = 2'b01;
    tick();
    M = 2'b00;
    push_exp(3'b111, 2'b10, 2'b01, 2'b00);
    tick();
    check("clr_fresh_commit_state", Chan, 3);
    Valid = 1'b0;
    tick();
    check("clr_fresh_frame", {Strobe, U, V, W}, {3'b111, 2'b10, 2'b01, 2'b00});

    // Mode toggled mid-frame: the frame still completes in auto mode.
    Mode = 1'b0; Valid = 1'b1; M = 2'b11;
    tick();
    Mode = 1'b1; S = 2'd0; M = 2'b00;
    tick();
    check("modechg_chan", Chan, 2);
    check("modechg_no_write", {Strobe, U}, {3'b000, 2'b10});
    M = 2'b01;
    push_exp(3'b111, 2'b11, 2'b00, 2'b01);
    tick();
    check("modechg_commit_state", Chan, 3);
    Valid = 1'b0; Mode = 1'b0;
    tick();
    check("modechg_frame", {U, V, W}, {2'b11, 2'b00, 2'b01});

    // Two back-to-back frames with Valid held high for 8 cycles.
    strobe_pulses = 0;
    Valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      case (i % 4)
        0: begin w0 = WIDTH'($urandom_range(0, 3)); M = w0; end
        1: begin w1 = WIDTH'($urandom_range(0, 3)); M = w1; end
        2: begin
          w2 = WIDTH'($urandom_range(0, 3)); M = w2;
          push_exp(3'b111, w0, w1, w2);
        end
        default: M = WIDTH'($urandom_range(0, 3));
      endcase
      tick();
      if (Strobe == 3'b111) strobe_pulses++;
    end
    Valid = 1'b0;
    check("b2b_pulses", strobe_pulses, 2);
    check("b2b_last_frame", {U, V, W}, {w0, w1, w2});
    tick();

    // Reset during ST_COMMIT suppresses the commit.
    Mode = 1'b0; Valid = 1'b1; M = 2'b01;
    tick();
    M = 2'b01;
    tick();
    M = 2'b01;
    tick();
    check("rstc_chan", Chan, 3);
    Valid = 1'b0;
    #2 Reset = 1'b1;
    #1;
    check("rstc_outputs", {Strobe, U, V, W}, 0);
    check("rstc_chan_idle", Chan, 0);
    @(negedge Clock) Reset = 1'b0;
    tick();
    tick();
    check("rstc_no_commit", {Strobe, U, V, W, Err}, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
